host_link_sequencer: RTL

HOST_LINK_SEQUENCER -- requirements
Module: host_link_sequencer

---
 rtl/host_link_sequencer_pkg.sv | 24 ++
 rtl/host_link_timeout.sv | 30 +++
 rtl/host_link_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/host_link_sequencer_pkg.sv
// Shared definitions for the host link sequencer: FSM encoding, result codes
// and the opcode legality helper.
package host_link_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DISPATCH,
    WAIT_RSP,
    SEND,
    DRAIN
  } linkState_e;

  localparam logic [3:0] RESULT_OK      = 4'h0;
  localparam logic [3:0] RESULT_TIMEOUT = 4'h1;
  localparam logic [3:0] RESULT_BAD_OP  = 4'h2;

  localparam logic [3:0] OPCODE_LOOPBACK = 4'h0;

  function automatic logic isLegalOpcode(input logic [3:0] opcode, input int numOps);
    return int'({28'd0, opcode}) < numOps;
  endfunction

endpackage

// File: rtl/host_link_timeout.sv
// Saturating wait counter; expired rises once the count reaches TIMEOUT_CYCLES-1
// and the counter then holds there instead of wrapping.
module host_link_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic masterClock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CountWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT_CYCLES - 1);

  logic [CountWidth-1:0] count;

  assign expired = (count == LastCount);

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/host_link_sequencer.sv
// Bridges packets from the wide UART I/O block to a DUT command/response port,
// replying with a tagged status byte and payload for every packet received.
module host_link_sequencer
  import host_link_sequencer_pkg::*;
#(
  parameter int          WIDTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int          NUM_OPS        = 8
) (
  input  logic               masterClock,
  input  logic               reset,
  input  logic               dataReceived,
  input  logic [7:0]         control,
  input  logic [WIDTH*8-1:0] inputData,
  input  logic               transmitting,
  output logic               clearDR,
  output logic               transmit,
  output logic [7:0]         status,
  output logic [WIDTH*8-1:0] outputData,
  output logic               cmdValid,
  input  logic               cmdReady,
  output logic [3:0]         cmdOpcode,
  output logic [WIDTH*8-1:0] cmdData,
  input  logic               rspValid,
  input  logic [WIDTH*8-1:0] rspData,
  output logic               busy
);

  linkState_e state;
  logic [3:0] tagReg;
  logic       handshake;
  logic       timerClear;
  logic       timerEnable;
  logic       timerExpired;

  assign busy        = (state != IDLE);
  assign handshake   = cmdValid && cmdReady;
  // The counter restarts for DISPATCH and again at the handshake, so the
  // handshake phase and the response phase each get a full timeout budget.
  assign timerClear  = (state == CAPTURE) || ((state == DISPATCH) && handshake);
  assign timerEnable = ((state == DISPATCH) && !handshake) ||
                       ((state == WAIT_RSP) && !rspValid);

  host_link_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) timeoutCounter (
    .masterClock(masterClock),
    .reset      (reset),
    .clear      (timerClear),
    .enable     (timerEnable),
    .expired    (timerExpired)
  );

  // Main sequencer; status/outputData are only written on the way into SEND.
  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tagReg     <= '0;
      clearDR    <= 1'b0;
      transmit   <= 1'b0;
      cmdValid   <= 1'b0;
      status     <= '0;
      outputData <= '0;
      cmdOpcode  <= '0;
      cmdData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dataReceived) begin
            tagReg    <= control[7:4];
            cmdOpcode <= control[3:0];
            cmdData   <= inputData;
            clearDR   <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!dataReceived) begin
            clearDR <= 1'b0;
            if (cmdOpcode == OPCODE_LOOPBACK) begin
              status     <= {tagReg, RESULT_OK};
              outputData <= cmdData;
              transmit   <= 1'b1;
              state      <= SEND;
            end else if (!isLegalOpcode(cmdOpcode, NUM_OPS)) begin
              status     <= {tagReg, RESULT_BAD_OP};
              outputData <= '0;
              transmit   <= 1'b1;
              state      <= SEND;
            end else begin
              cmdValid <= 1'b1;
              state    <= DISPATCH;
            end
          end
        end
        DISPATCH: begin
          if (handshake) begin
            cmdValid <= 1'b0;
            state    <= WAIT_RSP;
          end else if (timerExpired) begin
            cmdValid   <= 1'b0;
            status     <= {tagReg, RESULT_TIMEOUT};
            outputData <= '0;
            transmit   <= 1'b1;
            state      <= SEND;
          end
        end
        WAIT_RSP: begin
          if (rspValid) begin
            status     <= {tagReg, RESULT_OK};
            outputData <= rspData;
            transmit   <= 1'b1;
            state      <= SEND;
          end else if (timerExpired) begin
            status     <= {tagReg, RESULT_TIMEOUT};
            outputData <= '0;
            transmit   <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (transmitting) begin
            transmit <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!transmitting) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
